// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges in-order writeback (A) with a long-latency
// unit (B), with starvation protection for B and a pending-write scoreboard for decode.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        rf_wr_en,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wr_data
);

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  logic        starve;
  logic        issue_fire;
  logic [3:0]  wait_cnt_d, wait_cnt_q;
  logic [31:0] pend_d, pend_q;
  logic        rf_wr_en_d, rf_wr_en_q;
  logic [4:0]  rf_rd_d, rf_rd_q;
  logic [31:0] rf_wr_data_d, rf_wr_data_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    starve      = (wait_cnt_q >= MaxWaitC);
    b_ready     = b_valid & (~a_valid | starve);
    a_ready     = a_valid & ~(b_valid & starve);
    issue_ready = ~((issue_rd != 5'd0) & pend_q[issue_rd]);
    issue_fire  = issue_valid & issue_ready & (issue_rd != 5'd0);
    hazard      = ((rs1 != 5'd0) & pend_q[rs1]) | ((rs2 != 5'd0) & pend_q[rs2]);

    wait_cnt_d   = 4'd0;
    pend_d       = pend_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wr_data_d = rf_wr_data_q;

    if (b_valid && !b_ready) begin
      wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end

    // Clear before set so an issue to the register B is retiring keeps it pending.
    if (b_ready) begin
      pend_d[b_rd] = 1'b0;
    end
    if (issue_fire) begin
      pend_d[issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;

    if (b_ready) begin
      rf_wr_en_d   = (b_rd != 5'd0);
      rf_rd_d      = b_rd;
      rf_wr_data_d = b_data;
    end else if (a_ready) begin
      rf_wr_en_d   = (a_rd != 5'd0);
      rf_rd_d      = a_rd;
      rf_wr_data_d = a_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q   <= 4'd0;
      pend_q       <= 32'd0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_q      <= 5'd0;
      rf_wr_data_q <= 32'd0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      pend_q       <= pend_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_q      <= rf_rd_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wr_data = rf_wr_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk, rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, issue_ready, hazard, rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wr_data;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_a_ready;
    logic        e_b_ready;
    logic        e_issue_ready;
    logic        e_hazard;
    logic        e_wr_en;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic bv, input logic [4:0] brd, input logic [31:0] bd,
    input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
    input logic ea, input logic eb, input logic ei, input logic eh,
    input logic ew, input logic [4:0] erd, input logic [31:0] ed);
    vec_t v;
    v.a_valid = av;  v.a_rd = ard;  v.a_data = ad;
    v.b_valid = bv;  v.b_rd = brd;  v.b_data = bd;
    v.issue_valid = iv; v.issue_rd = ird; v.rs1 = r1; v.rs2 = r2;
    v.e_a_ready = ea; v.e_b_ready = eb; v.e_issue_ready = ei; v.e_hazard = eh;
    v.e_wr_en = ew; v.e_rd = erd; v.e_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_valid = v.a_valid; a_rd = v.a_rd; a_data = v.a_data;
    b_valid = v.b_valid; b_rd = v.b_rd; b_data = v.b_data;
    issue_valid = v.issue_valid; issue_rd = v.issue_rd;
    rs1 = v.rs1; rs2 = v.rs2;
  endtask

  // Drive at the falling edge, check combinational outputs, then registered ones after the rising edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, ".a_ready"},     32'(a_ready),     32'(v.e_a_ready));
    check({tag, ".b_ready"},     32'(b_ready),     32'(v.e_b_ready));
    check({tag, ".issue_ready"}, 32'(issue_ready), 32'(v.e_issue_ready));
    check({tag, ".hazard"},      32'(hazard),      32'(v.e_hazard));
    @(posedge clk);
    #1;
    check({tag, ".rf_wr_en"},   32'(rf_wr_en), 32'(v.e_wr_en));
    check({tag, ".rf_rd"},      32'(rf_rd),    32'(v.e_rd));
    check({tag, ".rf_wr_data"}, rf_wr_data,    v.e_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset.rf_wr_en",   32'(rf_wr_en), 32'd0);
    check("reset.rf_rd",      32'(rf_rd),    32'd0);
    check("reset.rf_wr_data", rf_wr_data,    32'd0);
    check("reset.hazard",     32'(hazard),   32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural model state: set of pending registers, refusal streak, last write-port contents.
  bit          m_pend [32];
  int          m_wait;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wait = 0;
    m_rd   = 5'd0;
    m_data = 32'd0;
  endtask

  function automatic bit is_pending(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  // Fill in expectations for v from the model, then advance the model by one cycle.
  task automatic model_step(inout vec_t v);
    bit b_wins, a_wins, fire;
    b_wins = v.b_valid && (m_wait >= MAX_WAIT || !v.a_valid);
    a_wins = v.a_valid && !b_wins;
    fire   = v.issue_valid && !is_pending(v.issue_rd) && v.issue_rd != 5'd0;
    v.e_a_ready     = a_wins;
    v.e_b_ready     = b_wins;
    v.e_issue_ready = !is_pending(v.issue_rd);
    v.e_hazard      = is_pending(v.rs1) || is_pending(v.rs2);
    v.e_wr_en       = 1'b0;
    if (b_wins) begin
      v.e_wr_en = (v.b_rd != 5'd0); m_rd = v.b_rd; m_data = v.b_data;
    end else if (a_wins) begin
      v.e_wr_en = (v.a_rd != 5'd0); m_rd = v.a_rd; m_data = v.a_data;
    end
    v.e_rd   = m_rd;
    v.e_data = m_data;
    if (v.b_valid && !b_wins) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    else                      m_wait = 0;
    if (b_wins) m_pend[v.b_rd] = 1'b0;
    if (fire)   m_pend[v.issue_rd] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [9];
    vec_t v;

    rst = 1'b1;
    do_reset();

    // Directed table: A writes, x0 writes, scoreboard set/block/clear, x0 issue, contention.
    tbl[0] = mk(1, 5, 32'h12345678, 0, 0, 0,           0, 0, 0, 0, 1, 0, 1, 0, 1, 5, 32'h12345678);
    tbl[1] = mk(1, 0, 32'hDEADBEEF, 0, 0, 0,           0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'hDEADBEEF);
    tbl[2] = mk(0, 0, 0,            0, 0, 0,           1, 7, 7, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF);
    tbl[3] = mk(0, 0, 0,            0, 0, 0,           1, 7, 7, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF);
    tbl[4] = mk(0, 0, 0,            1, 7, 32'hA5A5A5A5, 0, 0, 7, 0, 0, 1, 1, 1, 1, 7, 32'hA5A5A5A5);
    tbl[5] = mk(0, 0, 0,            0, 0, 0,           0, 0, 7, 0, 0, 0, 1, 0, 0, 7, 32'hA5A5A5A5);
    tbl[6] = mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 0, 0, 0, 1, 0, 0, 7, 32'hA5A5A5A5);
    tbl[7] = mk(1, 3, 32'h1,        1, 4, 32'h2,       0, 0, 0, 0, 1, 0, 1, 0, 1, 3, 32'h1);
    tbl[8] = mk(0, 0, 0,            1, 4, 32'h2,       0, 4, 0, 0, 0, 1, 1, 0, 1, 4, 32'h2);
    for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Starvation: A and B held valid; B must win on the fifth cycle only.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bit bw;
      bw = (i == 4);
      v = mk(1, 10, 32'h100 + 32'(i), 1, 11, 32'hBBBB0000 + 32'(i), 0, 0, 0, 0,
             !bw, bw, 1, 0, 1, bw ? 5'd11 : 5'd10, bw ? 32'hBBBB0000 + 32'(i) : 32'h100 + 32'(i));
      apply(v, $sformatf("starve%0d", i));
    end

    // Issue and B retirement to the same register in one cycle: the new issue stays pending.
    do_reset();
    apply(mk(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 9, 0, 1, 1, 0, 1, 9, 32'h99), "setclr0");
    apply(mk(0, 0, 0, 0, 0, 0,      1, 9, 0, 9, 0, 0, 0, 1, 0, 9, 32'h99), "setclr1");
    apply(mk(0, 0, 0, 1, 9, 32'h9A, 0, 0, 0, 9, 0, 1, 1, 1, 1, 9, 32'h9A), "setclr2");
    apply(mk(0, 0, 0, 0, 0, 0,      0, 9, 0, 9, 0, 0, 1, 0, 0, 9, 32'h9A), "setclr3");

    // Asynchronous reset in the middle of a cycle drops the launched write and pending bits.
    apply(mk(1, 5, 32'h55, 0, 0, 0, 1, 12, 12, 0, 1, 0, 1, 0, 1, 5, 32'h55), "arst0");
    #2;
    rst = 1'b1;
    #1;
    check("arst.rf_wr_en",    32'(rf_wr_en),    32'd0);
    check("arst.hazard",      32'(hazard),      32'd0);
    check("arst.issue_ready", 32'(issue_ready), 32'd1);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 12, 12, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("arst.hold_wr_en", 32'(rf_wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 12, 12, 0, 0, 0, 1, 0, 0, 0, 0), "arst1");

    // Randomized traffic against the behavioural model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             0, 0, 0, 0, 0, 0, 0);
      model_step(v);
      apply(v, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
